mem_port_arbiter: RTL

// - Shares the single unified memory port between instruction fetch (IF) and the load/store stage (MEM).
// - Serialises requests with one transaction outstanding; data wins over fetch, with a one-shot fairness override.
// - Generates stall_o, which feeds stall_i of the decode stage and the IF/EX pipeline registers.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and load/store, one transaction in flight.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
`ifdef MEM_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [2:0]  d_size_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [2:0]  mem_size_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic        timeout_o
`endif
);

    localparam logic [2:0] SIZE_WORD = 3'd4;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_IF = 2'd1;
    localparam logic [1:0] WAIT_D  = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       fair_q;
    logic       idle;
    logic       in_wait;
    logic       sel_d;
    logic       sel_if;
    logic       grant;
    logic       fire;
    logic       rsp;

    assign idle    = (state_q == IDLE);
    assign in_wait = (state_q == WAIT_IF) || (state_q == WAIT_D);

    // Data has priority unless the previous data grant overtook a pending fetch.
    assign sel_d  = idle & d_req_i & (~if_req_i | ~fair_q);
    assign sel_if = idle & if_req_i & ~sel_d;

    assign mem_req_o   = idle & (if_req_i | d_req_i);
    assign mem_we_o    = sel_d & d_we_i;
    assign mem_size_o  = sel_d ? d_size_i : (sel_if ? SIZE_WORD : 3'd0);
    assign mem_addr_o  = sel_d ? d_addr_i : (sel_if ? if_addr_i : 32'h0);
    assign mem_wdata_o = sel_d ? d_wdata_i : 32'h0;

    assign grant    = mem_req_o & mem_gnt_i;
    assign d_gnt_o  = grant & sel_d;
    assign if_gnt_o = grant & sel_if;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt_q;
    logic          timeout_q;

    assign fire      = in_wait & ~mem_rvalid_i & (wait_cnt_q == CW'(TIMEOUT_CYCLES));
    assign timeout_o = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (grant) begin
                wait_cnt_q <= '0;
            end else if (in_wait && !mem_rvalid_i && !fire) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (fire) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign fire = 1'b0;
`endif

    // A watchdog completion returns zero data rather than whatever is on the bus.
    assign rsp         = in_wait & (mem_rvalid_i | fire);
    assign if_rvalid_o = rsp & (state_q == WAIT_IF);
    assign d_rvalid_o  = rsp & (state_q == WAIT_D);
    assign if_rdata_o  = (if_rvalid_o & mem_rvalid_i) ? mem_rdata_i : 32'h0;
    assign d_rdata_o   = (d_rvalid_o & mem_rvalid_i) ? mem_rdata_i : 32'h0;

    assign stall_o = (d_req_i & ~d_rvalid_o) | (if_req_i & ~if_rvalid_o);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = sel_d ? WAIT_D : WAIT_IF;
            WAIT_IF: if (rsp) state_d = IDLE;
            WAIT_D:  if (rsp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fair_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (d_gnt_o && if_req_i) begin
                fair_q <= 1'b1;
            end else if (if_gnt_o) begin
                fair_q <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    // Requesters must hold their request until the response pulse.
    a_if_hold: assert property (@(posedge clk) disable iff (!rst_n) (state_q == WAIT_IF) |-> if_req_i)
        else $error("if_req_i dropped while fetch outstanding");
    a_d_hold: assert property (@(posedge clk) disable iff (!rst_n) (state_q == WAIT_D) |-> d_req_i)
        else $error("d_req_i dropped while data access outstanding");
`endif

endmodule
